demux_collect_8bit: RTL and testbench
=====================================

# demux_collect_8bit

Sequential 1-to-8 bit collector: the inverse of the 8:1 select path in the ALU result mux. It takes a single data bit per write and steers it into one of eight registered outputs O0..O7, either at an explicit address (S0,S1,S2) or at an internal auto-incrementing pointer. Once all eight positions are written, it presents the assembled byte with a valid/ack handshake. It sits between bit-serial sources, such as test/scan shifters and per-bit ALU result taps, and byte-wide consumers.

## Interface
Parameters:
- none (width fixed at 8 positions, 3-bit select)

Ports:
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high reset
- D  input  1  data bit to be written
- S0  input  1  select MSB (addressed mode)
- S1  input  1  select middle bit
- S2  input  1  select LSB
- wr  input  1  write strobe; accepted only when wr_ready=1
- seq_mode  input  1  0 = addressed write, 1 = sequential write at ptr
- out_ack  input  1  consumer acknowledge of a full byte
- O0..O7  output  1 each  registered collected bits; position n = {S0,S1,S2} = n
- wr_ready  output  1  = ~full (combinational from state)
- full  output  1  all 8 positions written; byte valid
- mask  output  8  per-position written flags, bit n = On written this frame
- ptr  output  3  sequential write pointer
- ovf  output  1  one-cycle pulse: wr asserted while full (write dropped)

## Operation
- Reset (reset=1 at a rising edge):
  - O0..O7=0, mask=0, ptr=0, full=0, ovf=0.
  - Reset overrides wr and out_ack in the same cycle.
  - Reset mid-frame discards all partial data.
- State is implicit in {full, mask, ptr}. There are two phases:
  - COLLECT (full=0): writes are accepted.
  - HOLD (full=1): writes are refused; O and mask are frozen.
- Accepted write, when wr=1 and full=0, selects target position p:
  - seq_mode=0: p = 4*S0 + 2*S1 + S2. ptr is unchanged.
  - seq_mode=1: p = ptr, then ptr <= ptr+1 mod 8 (7 wraps to 0).
  - Then Op <= D and mask[p] <= 1.
- Overwrite: writing an already-masked position replaces Op and leaves mask unchanged. It counts nothing extra.
- full <= 1 at the edge where the accepted write makes mask == 8'hFF. Partial masks never set full.
- In HOLD:
  - wr=1 drops the write and pulses ovf=1 for the following cycle.
  - out_ack=1 at an edge: mask <= 0, ptr <= 0, full <= 0. O0..O7 keep their values until overwritten.
- out_ack while full=0 is ignored.
- wr and out_ack at the same edge while full=1: the ack is taken and the write is dropped, because wr_ready was 0 that cycle. ovf pulses.
- Mode may change on any cycle. Addressed writes never move ptr, and ptr keeps advancing from its current value. Mixed-mode frames are legal, and full depends only on mask.

## Timing
- Write latency is 1 cycle: Op, mask and ptr reflect a write on the edge where wr is sampled.
- full rises on the same edge as the 8th distinct position's write. wr_ready falls combinationally with full.
- The earliest next-frame write is the cycle after the out_ack edge. Minimum frame is 8 accepted writes, so full can assert 8 cycles after the first write and re-arm 1 cycle after ack.
- ovf is registered and high for exactly 1 cycle per dropped write.
- All outputs are registered except wr_ready.

## Test plan
- Reset then sequential fill: seq_mode=1, D = 1,0,1,1,0,0,1,0 on 8 consecutive wr cycles.
  - Required: O0..O7 = 1,0,1,1,0,0,1,0, full=1 after the 8th edge, ptr=0 (wrapped), mask=FF.
- Addressed fill out of order: write positions 7,0,4 (S=1,0,0),2,5,1,6,3 with D = position parity.
  - Required: full only after the 8th write, each On = n mod 2, ptr stays 0.
- Overwrite: addressed-write position 3 twice (D=1 then 0), then fill the rest.
  - Required: O3=0, mask[3] set once, full after 8 distinct positions (9 writes).
- Overflow and ack: with full=1, hold wr=1 for 2 cycles, then assert wr=1 with out_ack=1.
  - Required: ovf pulses each dropped write, O unchanged, ack clears full/mask/ptr, and the simultaneous write is dropped.
- Mixed mode: 3 sequential writes (ptr→3), then addressed write to position 6, then 4 sequential writes.
  - Required: ptr=7, mask=0xFF only if position 7 is covered; otherwise full=0. Check exact mask=8'b01111111 (bit 6 set) and full=0.
- Reset mid-frame: after 5 writes, assert reset for 1 cycle with wr=1.
  - Required: all outputs 0, mask=0, the write ignored, and a fresh 8-write fill completes normally.

Source files
------------

// File: rtl/demux_collect_8bit.sv
// Purpose : 1-to-8 bit collector; steers serial bits into eight registered outputs and flags a full byte.
// Latency : 1 cycle from an accepted write to O/mask/ptr; full rises on the edge of the 8th distinct position.
// Backpres: wr_ready = ~full; writes while full are dropped and reported by a one-cycle ovf pulse.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   D                data bit to write
//   S0,S1,S2         addressed-mode position, S0 is the MSB
//   wr, seq_mode     write strobe; 0 = addressed write, 1 = write at ptr and advance ptr
//   out_ack          consumer acknowledge; clears the frame while full
//   O0..O7           collected bits, position n = {S0,S1,S2}
//   wr_ready, full   write acceptance / byte valid
//   mask, ptr, ovf   per-position written flags, sequential pointer, dropped-write pulse
module demux_collect_8bit (
  input  logic       clk,
  input  logic       reset,
  input  logic       D,
  input  logic       S0,
  input  logic       S1,
  input  logic       S2,
  input  logic       wr,
  input  logic       seq_mode,
  input  logic       out_ack,
  output logic       O0,
  output logic       O1,
  output logic       O2,
  output logic       O3,
  output logic       O4,
  output logic       O5,
  output logic       O6,
  output logic       O7,
  output logic       wr_ready,
  output logic       full,
  output logic [7:0] mask,
  output logic [2:0] ptr,
  output logic       ovf
);

  logic [7:0] bits;
  logic [2:0] pos;
  logic [7:0] pos_onehot;

  // Target position for a write this cycle; only used when the write is accepted.
  always_comb begin
    pos        = seq_mode ? ptr : {S0, S1, S2};
    pos_onehot = 8'b0000_0001 << pos;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bits <= 8'h00;
      mask <= 8'h00;
      ptr  <= 3'd0;
      full <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      // Any write while full is refused, including one coincident with out_ack.
      ovf <= wr && full;
      if (full) begin
        // O keeps the old byte after ack; only the bookkeeping restarts.
        if (out_ack) begin
          mask <= 8'h00;
          ptr  <= 3'd0;
          full <= 1'b0;
        end
      end else if (wr) begin
        bits[pos] <= D;
        mask      <= mask | pos_onehot;
        if (seq_mode) begin
          ptr <= ptr + 3'd1;
        end
        // Overwrites of an already-set position leave the mask unchanged and cannot complete a frame.
        if ((mask | pos_onehot) == 8'hFF) begin
          full <= 1'b1;
        end
      end
    end
  end

  assign wr_ready = ~full;
  assign {O7, O6, O5, O4, O3, O2, O1, O0} = bits;

endmodule

// File: tb/tb_demux_collect_8bit.sv
module tb_demux_collect_8bit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       D = 1'b0;
  logic       S0 = 1'b0;
  logic       S1 = 1'b0;
  logic       S2 = 1'b0;
  logic       wr = 1'b0;
  logic       seq_mode = 1'b0;
  logic       out_ack = 1'b0;
  logic       O0, O1, O2, O3, O4, O5, O6, O7;
  logic       wr_ready, full, ovf;
  logic [7:0] mask;
  logic [2:0] ptr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, updated from the behavioural description of the block.
  logic [7:0] m_o    = 8'h00;
  logic [7:0] m_mask = 8'h00;
  logic [2:0] m_ptr  = 3'd0;
  logic       m_full = 1'b0;
  logic       m_ovf  = 1'b0;
  logic       prev_full = 1'b0;
  logic [7:0] sb[$];

  demux_collect_8bit dut (
    .clk(clk), .reset(reset), .D(D), .S0(S0), .S1(S1), .S2(S2),
    .wr(wr), .seq_mode(seq_mode), .out_ack(out_ack),
    .O0(O0), .O1(O1), .O2(O2), .O3(O3), .O4(O4), .O5(O5), .O6(O6), .O7(O7),
    .wr_ready(wr_ready), .full(full), .mask(mask), .ptr(ptr), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dut_byte();
    return {O7, O6, O5, O4, O3, O2, O1, O0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare every output 1ns after the edge.
  task automatic cyc(input logic w, input logic d, input logic [2:0] sel,
                     input logic sq, input logic ak, input logic rs);
    logic [2:0] p;
    wr = w; D = d; {S0, S1, S2} = sel; seq_mode = sq; out_ack = ak; reset = rs;
    if (rs) begin
      m_o = 8'h00; m_mask = 8'h00; m_ptr = 3'd0; m_full = 1'b0; m_ovf = 1'b0;
    end else begin
      m_ovf = w && m_full;
      if (m_full) begin
        if (ak) begin
          m_mask = 8'h00; m_ptr = 3'd0; m_full = 1'b0;
        end
      end else if (w) begin
        p = sq ? m_ptr : sel;
        m_o[p] = d;
        m_mask[p] = 1'b1;
        if (sq) m_ptr = m_ptr + 3'd1;
        if (m_mask == 8'hFF) begin
          m_full = 1'b1;
          sb.push_back(m_o);
        end
      end
    end
    @(posedge clk);
    #1;
    wr = 1'b0; out_ack = 1'b0; reset = 1'b0;
    chk("o_byte",   {24'd0, dut_byte()}, {24'd0, m_o});
    chk("mask",     {24'd0, mask},       {24'd0, m_mask});
    chk("ptr",      {29'd0, ptr},        {29'd0, m_ptr});
    chk("full",     {31'd0, full},       {31'd0, m_full});
    chk("wr_ready", {31'd0, wr_ready},   {31'd0, ~m_full});
    chk("ovf",      {31'd0, ovf},        {31'd0, m_ovf});
    // Scoreboard: each completed byte is popped when the DUT raises full.
    if (full === 1'b1 && prev_full !== 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_full", 32'd1, 32'd0);
      end else begin
        chk("sb_byte", {24'd0, dut_byte()}, {24'd0, sb.pop_front()});
      end
    end
    prev_full = full;
  endtask

  initial begin
    logic [7:0] pat;
    logic [2:0] order [8];
    logic [7:0] rnd;

    // Reset state.
    cyc(0, 0, 3'd0, 0, 0, 1);
    chk("reset_byte", {24'd0, dut_byte()}, 32'h00);
    chk("reset_full", {31'd0, full}, 32'd0);

    // Sequential fill: D = 1,0,1,1,0,0,1,0 into O0..O7.
    pat = 8'b0100_1101;
    for (int i = 0; i < 8; i++) cyc(1, pat[i], 3'd0, 1, 0, 0);
    chk("seq_byte", {24'd0, dut_byte()}, 32'h4D);
    chk("seq_mask", {24'd0, mask}, 32'hFF);
    chk("seq_ptr_wrap", {29'd0, ptr}, 32'd0);
    chk("seq_full", {31'd0, full}, 32'd1);
    cyc(0, 0, 3'd0, 0, 1, 0);

    // Addressed fill out of order, D = position parity.
    order = '{3'd7, 3'd0, 3'd4, 3'd2, 3'd5, 3'd1, 3'd6, 3'd3};
    for (int i = 0; i < 8; i++) begin
      cyc(1, order[i][0], order[i], 0, 0, 0);
      if (i == 6) chk("addr_full_before_8th", {31'd0, full}, 32'd0);
    end
    chk("addr_byte", {24'd0, dut_byte()}, 32'hAA);
    chk("addr_ptr", {29'd0, ptr}, 32'd0);
    chk("addr_full", {31'd0, full}, 32'd1);
    cyc(0, 0, 3'd0, 0, 1, 0);

    // Overwrite position 3, then fill the rest with 1s: 9 writes, 8 distinct positions.
    cyc(1, 1, 3'd3, 0, 0, 0);
    cyc(1, 0, 3'd3, 0, 0, 0);
    chk("ovw_mask", {24'd0, mask}, 32'h08);
    order = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7};
    for (int i = 0; i < 7; i++) cyc(1, 1, order[i], 0, 0, 0);
    chk("ovw_byte", {24'd0, dut_byte()}, 32'hF7);
    chk("ovw_full", {31'd0, full}, 32'd1);

    // Overflow: two dropped writes, then wr together with ack.
    cyc(1, 0, 3'd0, 1, 0, 0);
    chk("ovf_1", {31'd0, ovf}, 32'd1);
    cyc(1, 0, 3'd1, 0, 0, 0);
    chk("ovf_2", {31'd0, ovf}, 32'd1);
    chk("ovf_byte_frozen", {24'd0, dut_byte()}, 32'hF7);
    cyc(1, 0, 3'd2, 0, 1, 0);
    chk("ack_ovf", {31'd0, ovf}, 32'd1);
    chk("ack_full", {31'd0, full}, 32'd0);
    chk("ack_mask", {24'd0, mask}, 32'h00);
    chk("ack_byte_kept", {24'd0, dut_byte()}, 32'hF7);
    cyc(0, 0, 3'd0, 0, 0, 0);
    chk("ovf_clear", {31'd0, ovf}, 32'd0);

    // Mixed mode: 3 sequential, addressed 6, 4 sequential.
    for (int i = 0; i < 3; i++) cyc(1, 1, 3'd0, 1, 0, 0);
    chk("mix_ptr3", {29'd0, ptr}, 32'd3);
    cyc(1, 0, 3'd6, 0, 0, 0);
    chk("mix_ptr_hold", {29'd0, ptr}, 32'd3);
    for (int i = 0; i < 4; i++) cyc(1, 1, 3'd0, 1, 0, 0);
    chk("mix_ptr7", {29'd0, ptr}, 32'd7);
    chk("mix_mask", {24'd0, mask}, 32'h7F);
    chk("mix_full", {31'd0, full}, 32'd0);

    // Reset mid-frame with a write present, then a fresh random fill.
    cyc(0, 0, 3'd0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 1, 3'(i), 0, 0, 0);
    cyc(1, 1, 3'd5, 0, 0, 1);
    chk("rst_byte", {24'd0, dut_byte()}, 32'h00);
    chk("rst_mask", {24'd0, mask}, 32'h00);
    chk("rst_ptr", {29'd0, ptr}, 32'd0);
    rnd = 8'($urandom);
    for (int i = 0; i < 8; i++) cyc(1, rnd[i], 3'd0, 1, 0, 0);
    chk("fresh_byte", {24'd0, dut_byte()}, {24'd0, rnd});
    chk("fresh_full", {31'd0, full}, 32'd1);
    cyc(0, 0, 3'd0, 0, 1, 0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
